// File: rtl/mux_tree_tapbuf_cfgchain_pkg.sv
// Purpose: shared constants and helpers for configuration-bearing fabric blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_tree_tapbuf_cfgchain_pkg;

  // Expected XOR over a full chain (data + parity) for a valid word.
  localparam logic CFG_PARITY_EVEN = 1'b0;

  // Select width able to encode every input plus at least one tie-off code.
  function automatic int cfg_sel_w_f(input int n);
    return $clog2(n + 1);
  endfunction

  // Reset value of the active select: all-ones, which is always a tie-off code.
  function automatic logic [31:0] cfg_sel_rst_f(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mux_tree_tapbuf_cfgchain_cells.sv
// Purpose: library primitives used by the routing mux tree (2:1 mux, tap buffer).
// Latency: combinational.
// Backpressure: none.
module MUX2 (
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_s,
  output logic o_y
);
  assign o_y = i_s ? i_a1 : i_a0;
endmodule

module buf4 (
  input  logic i_a,
  output logic o_y
);
  assign o_y = i_a;
endmodule

// File: rtl/mux_tree_tapbuf_cfgchain_cfg_shadow_chain.sv
// Purpose: serial configuration shift register with registered tail and parity check.
// Latency: tail is the last chain flop, CHAIN_L cycles from head to tail.
// Backpressure: none; shifts only while i_en is high, otherwise holds.
module cfg_shadow_chain
  import mux_tree_tapbuf_cfgchain_pkg::*;
#(
  parameter int CHAIN_L = 5
) (
  input  logic               prog_clk,
  input  logic               prog_reset_n,
  input  logic               i_en,
  input  logic               i_head,
  output logic               o_tail,
  output logic [CHAIN_L-1:0] o_shadow,
  output logic               o_par_ok
);

  logic [CHAIN_L-1:0] r_shadow;

  // Shift new bits in at the LSB end; hold when not enabled.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_shadow <= '0;
    end else if (i_en) begin
      r_shadow <= {r_shadow[CHAIN_L-2:0], i_head};
    end
  end

  // Tail comes straight from the last flop, so there is no head-to-tail comb path.
  assign o_tail   = r_shadow[CHAIN_L-1];
  assign o_shadow = r_shadow;
  assign o_par_ok = ((^r_shadow) == CFG_PARITY_EVEN);

endmodule

// File: rtl/mux_tree_tapbuf_cfgchain.sv
// Purpose: N-input routing mux with serial config chain and parity-checked commit.
// Latency: new select visible on out the cycle after the commit edge; out is comb from in.
// Backpressure: none; a failed commit keeps the old path and raises sticky cfg_err.
module mux_tree_tapbuf_cfgchain
  import mux_tree_tapbuf_cfgchain_pkg::*;
#(
  parameter int N      = 8,
  parameter int SEL_W  = cfg_sel_w_f(N),
  parameter int PARITY = 1
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  input  logic [N-1:0]     in,
  input  logic             ccff_head,
  input  logic             prog_en,
  input  logic             cfg_commit,
  output logic             ccff_tail,
  output logic             out,
  output logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_err
);

  localparam int                 CHAIN_L = SEL_W + PARITY;
  localparam int                 M       = 1 << SEL_W;
  localparam logic [SEL_W-1:0]   SEL_RST = SEL_W'(cfg_sel_rst_f(SEL_W));

  logic [CHAIN_L-1:0] w_shadow;
  logic               w_par_ok;
  logic               w_commit_ok;
  logic [SEL_W-1:0]   w_code;
  logic [SEL_W-1:0]   r_sel;
  logic               r_err;
  logic [2*M-1:1]     w_node;

  cfg_shadow_chain #(
    .CHAIN_L (CHAIN_L)
  ) u_chain (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .i_en         (prog_en),
    .i_head       (ccff_head),
    .o_tail       (ccff_tail),
    .o_shadow     (w_shadow),
    .o_par_ok     (w_par_ok)
  );

  // The code always sits in the top SEL_W chain bits; the parity bit (if any) is bit 0.
  assign w_code      = w_shadow[CHAIN_L-1 -: SEL_W];
  assign w_commit_ok = (PARITY == 0) || w_par_ok;

  // Active select and sticky error: updated only on commit, using the pre-shift shadow.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_sel <= SEL_RST;
      r_err <= 1'b0;
    end else if (cfg_commit) begin
      if (w_commit_ok) begin
        r_sel <= w_code;
        r_err <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  // Leaves of the heap-indexed tree: real inputs, then constant-1 tie-offs.
  for (genvar j = 0; j < M; j++) begin : g_leaf
    if (j < N) begin : g_in
      assign w_node[M+j] = in[j];
    end else begin : g_tie
      assign w_node[M+j] = 1'b1;
    end
  end

  // Node i at depth D picks between children 2i/2i+1 using select bit SEL_W-1-D (MSB at root).
  for (genvar i = 1; i < M; i++) begin : g_mux
    localparam int D = $clog2(i + 1) - 1;
    MUX2 u_mux2 (
      .i_a0 (w_node[2*i]),
      .i_a1 (w_node[2*i+1]),
      .i_s  (r_sel[SEL_W-1-D]),
      .o_y  (w_node[i])
    );
  end

  buf4 u_tapbuf (
    .i_a (w_node[1]),
    .o_y (out)
  );

  assign cfg_sel = r_sel;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_mux_tree_tapbuf_cfgchain.sv
module tb_mux_tree_tapbuf_cfgchain;

  localparam int N = 8;
  localparam int L = 5;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_s;
  logic       head;
  logic       en;
  logic       commit;
  logic       tail;
  logic       out_s;
  logic [3:0] sel;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the last L bits shifted in, oldest first, plus active state.
  int m_win[$];
  int m_sel;
  int m_err;

  typedef struct {
    bit         en;
    bit         head;
    bit         commit;
    logic [7:0] inv;
    logic       exp_out;
    logic [3:0] exp_sel;
    logic       exp_err;
    logic       exp_tail;
  } vec_t;

  vec_t tbl[$];

  mux_tree_tapbuf_cfgchain #(.N(8), .SEL_W(4), .PARITY(1)) dut (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .in           (in_s),
    .ccff_head    (head),
    .prog_en      (en),
    .cfg_commit   (commit),
    .ccff_tail    (tail),
    .out          (out_s),
    .cfg_sel      (sel),
    .cfg_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    for (int i = 0; i < L; i++) m_win.push_back(0);
    m_sel = 15;
    m_err = 0;
  endtask

  // Commit looks at the window before this edge's shift, then the shift happens.
  task automatic model_edge(input bit e, input bit h, input bit c);
    int code;
    int ones;
    if (c) begin
      code = 8 * m_win[0] + 4 * m_win[1] + 2 * m_win[2] + m_win[3];
      ones = m_win[0] + m_win[1] + m_win[2] + m_win[3] + m_win[4];
      if (ones % 2 == 0) begin
        m_sel = code;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    if (e) begin
      void'(m_win.pop_front());
      m_win.push_back(int'(h));
    end
  endtask

  function automatic logic model_out(input logic [7:0] v);
    if (m_sel < N) return v[m_sel];
    return 1'b1;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".out"},  32'(out_s), 32'(model_out(in_s)));
    check({tag, ".sel"},  32'(sel),   32'(m_sel));
    check({tag, ".err"},  32'(err),   32'(m_err));
    check({tag, ".tail"}, 32'(tail),  32'(m_win[0]));
  endtask

  task automatic step(input bit e, input bit h, input bit c, input logic [7:0] v);
    en = e; head = h; commit = c; in_s = v;
    @(posedge clk);
    model_edge(e, h, c);
    #1;
  endtask

  task automatic shift_word(input int code, input int par, input logic [7:0] v);
    for (int b = 3; b >= 0; b--) step(1'b1, code[b], 1'b0, v);
    step(1'b1, par[0], 1'b0, v);
  endtask

  task automatic add(input bit e, input bit h, input bit c, input logic [7:0] v,
                     input logic o, input logic [3:0] s, input logic er, input logic t);
    vec_t r;
    r.en = e; r.head = h; r.commit = c; r.inv = v;
    r.exp_out = o; r.exp_sel = s; r.exp_err = er; r.exp_tail = t;
    tbl.push_back(r);
  endtask

  initial begin
    int pat[10];
    logic [7:0] r8;

    // Code 3 + parity 0, then commit, then in[3] drops
    add(1,0,0,8'hA5, 1,4'hF,0,0); add(1,0,0,8'hA5, 1,4'hF,0,0);
    add(1,1,0,8'hA5, 1,4'hF,0,0); add(1,1,0,8'hA5, 1,4'hF,0,0);
    add(1,0,0,8'hA5, 1,4'hF,0,0);
    add(0,0,1,8'h08, 1,4'h3,0,0);
    add(0,0,0,8'h00, 0,4'h3,0,0);
    // Code 5 with wrong parity, commit rejected
    add(1,0,0,8'h08, 1,4'h3,0,0); add(1,1,0,8'h08, 1,4'h3,0,1);
    add(1,0,0,8'h08, 1,4'h3,0,1); add(1,1,0,8'h08, 1,4'h3,0,0);
    add(1,1,0,8'h08, 1,4'h3,0,0);
    add(0,0,1,8'h08, 1,4'h3,1,0);
    // Code 6 correct parity, commit clears error
    add(1,0,0,8'h40, 0,4'h3,1,1); add(1,1,0,8'h40, 0,4'h3,1,0);
    add(1,1,0,8'h40, 0,4'h3,1,1); add(1,0,0,8'h40, 0,4'h3,1,1);
    add(1,0,0,8'h40, 0,4'h3,1,0);
    add(0,0,1,8'h40, 1,4'h6,0,0);
    // Code 9 (tie-off) committed
    add(1,1,0,8'h40, 1,4'h6,0,1); add(1,0,0,8'h40, 1,4'h6,0,1);
    add(1,0,0,8'h40, 1,4'h6,0,0); add(1,1,0,8'h40, 1,4'h6,0,0);
    add(1,0,0,8'h40, 1,4'h6,0,1);
    add(0,0,1,8'hFF, 1,4'h9,0,1);
    add(0,0,0,8'h00, 1,4'h9,0,1);

    // Reset state while held and after release with no activity
    rst_n = 1'b0; en = 0; head = 0; commit = 0; in_s = 8'hA5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", 32'(out_s), 32'd1);
    check("rst.sel", 32'(sel), 32'hF);
    check("rst.err", 32'(err), 32'd0);
    check("rst.tail", 32'(tail), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 8'hA5);
    check("idle.out", 32'(out_s), 32'd1);
    check("idle.sel", 32'(sel), 32'hF);
    check("idle.err", 32'(err), 32'd0);
    check("idle.tail", 32'(tail), 32'd0);

    // Table-driven directed sequence
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].head, tbl[i].commit, tbl[i].inv);
      check($sformatf("tbl%0d.out", i),  32'(out_s), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d.sel", i),  32'(sel),   32'(tbl[i].exp_sel));
      check($sformatf("tbl%0d.err", i),  32'(err),   32'(tbl[i].exp_err));
      check($sformatf("tbl%0d.tail", i), 32'(tail),  32'(tbl[i].exp_tail));
    end

    // Tail reproduces head 5 cycles later; out stays tied high (code 9)
    pat = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    for (int k = 0; k < 10; k++) begin
      r8 = 8'($urandom);
      step(1'b1, pat[k][0], 1'b0, r8);
      if (k >= 4) check($sformatf("delay%0d.tail", k), 32'(tail), 32'(pat[k-4]));
      check($sformatf("delay%0d.out", k), 32'(out_s), 32'd1);
    end
    check("delay.sel", 32'(sel), 32'h9);

    // Set up code 6 and a sticky error, then reset asynchronously mid-shift
    shift_word(6, 0, 8'h40);
    step(0, 0, 1, 8'h40);
    shift_word(5, 1, 8'h40);
    step(0, 0, 1, 8'h40);
    check("pre_rst.sel", 32'(sel), 32'h6);
    check("pre_rst.err", 32'(err), 32'd1);
    step(1, 1, 0, 8'h40);
    step(1, 1, 0, 8'h40);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.sel", 32'(sel), 32'hF);
    check("async_rst.out", 32'(out_s), 32'd1);
    check("async_rst.tail", 32'(tail), 32'd0);
    check("async_rst.err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Commit together with shift: the pre-shift code 3 is taken
    shift_word(3, 0, 8'h08);
    step(1, 1, 1, 8'h08);
    check("simul.sel", 32'(sel), 32'h3);
    check("simul.err", 32'(err), 32'd0);
    check("simul.out", 32'(out_s), 32'd1);
    // Shifted shadow now has odd parity: next commit must fail and keep code 3
    step(0, 0, 1, 8'h00);
    check("simul2.sel", 32'(sel), 32'h3);
    check("simul2.err", 32'(err), 32'd1);
    check("simul2.out", 32'(out_s), 32'd0);
    // Back-to-back commit after reloading a good word: each edge independent
    shift_word(7, 1, 8'h80);
    step(0, 0, 1, 8'h80);
    step(0, 0, 1, 8'h7F);
    check("hold_commit.sel", 32'(sel), 32'h7);
    check("hold_commit.err", 32'(err), 32'd0);
    check("hold_commit.out", 32'(out_s), 32'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 8'($urandom));
      check_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 3) == 0) begin
        in_s = 8'($urandom);
        #1;
        check($sformatf("rnd%0d.comb", c), 32'(out_s), 32'(model_out(in_s)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
